// File: rtl/dp_ctxt_split_sched.sv
// Arbitrates the split-banked ciphertext URAM store between a load requester
// and a stream requester, drives the store controls and tracks loaded splits.
module dp_ctxt_split_sched #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned NUM_SPLIT  = 4,
  parameter int unsigned SPLIT_W    = 2,
  parameter int unsigned RD_LEN     = 4096,
  parameter int unsigned URAM_DELAY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_req,
  input  logic [SPLIT_W-1:0]    i_wr_split,
  output logic                  o_wr_gnt,
  output logic                  o_wr_done,
  input  logic                  i_rd_req,
  input  logic [SPLIT_W-1:0]    i_rd_split,
  output logic                  o_rd_gnt,
  output logic                  o_rd_err,
  output logic                  o_rd_done,
  input  logic                  i_invalidate,
  output logic [SPLIT_W-1:0]    o_idx_split,
  output logic                  o_wruram_start,
  input  logic                  i_wruram_done,
  output logic [NUM_SPLIT-1:0]  o_uram_mem_en,
  output logic [NUM_SPLIT-1:0]  o_uram_we,
  output logic [ADDR_WIDTH-1:0] o_uram_rdaddr,
  output logic                  o_rd_valid,
  output logic [NUM_SPLIT-1:0]  o_split_loaded
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned DRN_W = $clog2(URAM_DELAY + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_LAUNCH,
    ST_WR_BUSY,
    ST_RD_BUSY,
    ST_RD_DRAIN
  } state_e;

  state_e                  state_q, state_d;
  logic                    wr_gnt_q, wr_gnt_d;
  logic                    wr_done_q, wr_done_d;
  logic                    rd_gnt_q, rd_gnt_d;
  logic                    rd_err_q, rd_err_d;
  logic                    rd_done_q, rd_done_d;
  logic [SPLIT_W-1:0]      idx_q, idx_d;
  logic                    wr_start_q, wr_start_d;
  logic [NUM_SPLIT-1:0]    mem_en_q, mem_en_d;
  logic [NUM_SPLIT-1:0]    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   rdaddr_q, rdaddr_d;
  logic [URAM_DELAY-1:0]   vld_q, vld_d;
  logic [NUM_SPLIT-1:0]    loaded_q, loaded_d;
  logic                    issue_q, issue_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DRN_W-1:0]        drn_q, drn_d;
  logic                    last_wr_q, last_wr_d;

  logic [NUM_SPLIT-1:0]    split_oh;
  logic                    serve_wr;
  logic                    serve_rd;

  assign split_oh = NUM_SPLIT'(1) << idx_q;
  // On contention the requester type that did not win last is served.
  assign serve_wr = i_wr_req & (~i_rd_req | ~last_wr_q);
  assign serve_rd = i_rd_req & ~serve_wr;

  always_comb begin
    state_d    = state_q;
    wr_gnt_d   = 1'b0;
    wr_done_d  = 1'b0;
    rd_gnt_d   = 1'b0;
    rd_err_d   = 1'b0;
    rd_done_d  = 1'b0;
    idx_d      = idx_q;
    wr_start_d = 1'b0;
    mem_en_d   = '0;
    we_d       = '0;
    rdaddr_d   = rdaddr_q;
    issue_d    = 1'b0;
    cnt_d      = cnt_q;
    drn_d      = drn_q;
    last_wr_d  = last_wr_q;
    loaded_d   = i_invalidate ? '0 : loaded_q;

    vld_d[0] = issue_q;
    for (int unsigned i = 1; i < URAM_DELAY; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    unique case (state_q)
      ST_IDLE: begin
        if (serve_wr) begin
          wr_gnt_d  = 1'b1;
          idx_d     = i_wr_split;
          last_wr_d = 1'b1;
          state_d   = ST_WR_LAUNCH;
        end else if (serve_rd) begin
          rd_gnt_d  = 1'b1;
          idx_d     = i_rd_split;
          last_wr_d = 1'b0;
          if (loaded_q[i_rd_split]) begin
            cnt_d   = '0;
            state_d = ST_RD_BUSY;
          end else begin
            rd_err_d = 1'b1;
          end
        end
      end
      ST_WR_LAUNCH: begin
        wr_start_d = 1'b1;
        mem_en_d   = split_oh;
        we_d       = split_oh;
        state_d    = ST_WR_BUSY;
      end
      ST_WR_BUSY: begin
        mem_en_d = split_oh;
        we_d     = split_oh;
        // Done is still high while the start pulse is on the wire; ignore it then.
        if (i_wruram_done && !wr_start_q) begin
          mem_en_d  = '0;
          we_d      = '0;
          wr_done_d = 1'b1;
          loaded_d  = loaded_d | split_oh;
          state_d   = ST_IDLE;
        end
      end
      ST_RD_BUSY: begin
        mem_en_d = split_oh;
        rdaddr_d = cnt_q[ADDR_WIDTH-1:0];
        issue_d  = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(RD_LEN - 1)) begin
          drn_d   = '0;
          state_d = ST_RD_DRAIN;
        end
      end
      ST_RD_DRAIN: begin
        if (drn_q == DRN_W'(URAM_DELAY)) begin
          rd_done_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          mem_en_d = split_oh;
          drn_d    = drn_q + DRN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_gnt_q   <= 1'b0;
      wr_done_q  <= 1'b0;
      rd_gnt_q   <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_done_q  <= 1'b0;
      idx_q      <= '0;
      wr_start_q <= 1'b0;
      mem_en_q   <= '0;
      we_q       <= '0;
      rdaddr_q   <= '0;
      vld_q      <= '0;
      loaded_q   <= '0;
      issue_q    <= 1'b0;
      cnt_q      <= '0;
      drn_q      <= '0;
      last_wr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_gnt_q   <= wr_gnt_d;
      wr_done_q  <= wr_done_d;
      rd_gnt_q   <= rd_gnt_d;
      rd_err_q   <= rd_err_d;
      rd_done_q  <= rd_done_d;
      idx_q      <= idx_d;
      wr_start_q <= wr_start_d;
      mem_en_q   <= mem_en_d;
      we_q       <= we_d;
      rdaddr_q   <= rdaddr_d;
      vld_q      <= vld_d;
      loaded_q   <= loaded_d;
      issue_q    <= issue_d;
      cnt_q      <= cnt_d;
      drn_q      <= drn_d;
      last_wr_q  <= last_wr_d;
    end
  end

  assign o_wr_gnt       = wr_gnt_q;
  assign o_wr_done      = wr_done_q;
  assign o_rd_gnt       = rd_gnt_q;
  assign o_rd_err       = rd_err_q;
  assign o_rd_done      = rd_done_q;
  assign o_idx_split    = idx_q;
  assign o_wruram_start = wr_start_q;
  assign o_uram_mem_en  = mem_en_q;
  assign o_uram_we      = we_q;
  assign o_uram_rdaddr  = rdaddr_q;
  assign o_rd_valid     = vld_q[URAM_DELAY-1];
  assign o_split_loaded = loaded_q;

endmodule

// File: tb/tb_dp_ctxt_split_sched.sv
// Bench for dp_ctxt_split_sched: table of load/stream operations plus reset
// and invalidate sequences; stream beats checked against a queue of addresses.
module tb_dp_ctxt_split_sched;

  localparam int unsigned AW = 4;
  localparam int unsigned NS = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned RL = 16;
  localparam int unsigned UD = 3;
  localparam int NV = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_wr_req, i_rd_req, i_invalidate, i_wruram_done;
  logic [SW-1:0] i_wr_split, i_rd_split;
  logic          o_wr_gnt, o_wr_done, o_rd_gnt, o_rd_err, o_rd_done;
  logic [SW-1:0] o_idx_split;
  logic          o_wruram_start, o_rd_valid;
  logic [NS-1:0] o_uram_mem_en, o_uram_we, o_split_loaded;
  logic [AW-1:0] o_uram_rdaddr;

  dp_ctxt_split_sched #(
    .ADDR_WIDTH(AW), .NUM_SPLIT(NS), .SPLIT_W(SW), .RD_LEN(RL), .URAM_DELAY(UD)
  ) dut (
    .clk(clk), .rst(rst),
    .i_wr_req(i_wr_req), .i_wr_split(i_wr_split), .o_wr_gnt(o_wr_gnt), .o_wr_done(o_wr_done),
    .i_rd_req(i_rd_req), .i_rd_split(i_rd_split), .o_rd_gnt(o_rd_gnt), .o_rd_err(o_rd_err),
    .o_rd_done(o_rd_done), .i_invalidate(i_invalidate), .o_idx_split(o_idx_split),
    .o_wruram_start(o_wruram_start), .i_wruram_done(i_wruram_done),
    .o_uram_mem_en(o_uram_mem_en), .o_uram_we(o_uram_we), .o_uram_rdaddr(o_uram_rdaddr),
    .o_rd_valid(o_rd_valid), .o_split_loaded(o_split_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [SW-1:0] ws;
    logic [SW-1:0] rs;
    int unsigned   nlow;
    logic          inv;
    logic          wr_first;
    logic          rd_err;
    logic [NS-1:0] loaded;
  } vec_t;

  vec_t vecs [NV];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // store write-sequencer model
  logic        st_pending = 1'b0;
  int unsigned st_low = 0;
  int unsigned store_nlow = 1;
  logic        inv_at_done = 1'b0;
  logic        inv_drv = 1'b0;

  // stream scoreboard
  int unsigned  exp_q[$];
  logic [AW-1:0] hist [0:UD];
  int beats, first_valid, last_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (inv_drv) begin
      i_invalidate = 1'b0;
      inv_drv = 1'b0;
    end
    if (o_wruram_start) begin
      st_pending = 1'b1;
    end else if (st_pending) begin
      i_wruram_done = 1'b0;
      st_low = store_nlow;
      st_pending = 1'b0;
    end else if (st_low > 0) begin
      st_low--;
      if (st_low == 0) begin
        i_wruram_done = 1'b1;
        if (inv_at_done) begin
          i_invalidate = 1'b1;
          inv_drv = 1'b1;
          inv_at_done = 1'b0;
        end
      end
    end
    for (int i = UD; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = o_uram_rdaddr;
    if (o_rd_valid) begin
      if (beats == 0) first_valid = cyc;
      last_valid = cyc;
      beats++;
      if (exp_q.size() == 0) chk("rd_beat_extra", 32'd1, 32'd0);
      else chk("rd_beat_addr", 32'(hist[UD]), exp_q.pop_front());
    end
  endtask

  task automatic wait_gnt(output logic gw, output logic gr, output int gcyc);
    int n = 0;
    while (!(o_wr_gnt || o_rd_gnt) && n < 200) begin
      tick();
      n++;
    end
    gw = o_wr_gnt;
    gr = o_rd_gnt;
    gcyc = cyc;
    if (!(gw || gr)) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_write(input logic [SW-1:0] s, input int unsigned nlow, input logic inv,
                          output int end_cyc);
    logic [NS-1:0] oh;
    int scyc, bad, n;
    oh = NS'(1) << s;
    bad = 0;
    n = 0;
    chk("wr_idx", 32'(o_idx_split), 32'(s));
    store_nlow = nlow;
    inv_at_done = inv;
    tick();
    scyc = cyc;
    chk("wr_start", 32'(o_wruram_start), 32'd1);
    chk("wr_we", 32'(o_uram_we), 32'(oh));
    chk("wr_en", 32'(o_uram_mem_en), 32'(oh));
    do begin
      tick();
      n++;
      if (!o_wr_done && (o_uram_we !== oh || o_uram_mem_en !== oh || o_wruram_start !== 1'b0))
        bad++;
    end while (!o_wr_done && n < 200);
    chk("wr_done_seen", 32'(o_wr_done), 32'd1);
    chk("wr_done_lat", 32'(cyc - scyc), 32'(nlow + 2));
    chk("wr_hold_we", 32'(bad), 32'd0);
    chk("wr_we_drop", 32'(o_uram_we), 32'd0);
    chk("wr_en_drop", 32'(o_uram_mem_en), 32'd0);
    end_cyc = cyc;
  endtask

  task automatic do_read(input logic [SW-1:0] s, input logic err, output int end_cyc);
    logic [NS-1:0] oh;
    int t, bad, n;
    oh = NS'(1) << s;
    t = cyc;
    bad = 0;
    n = 0;
    chk("rd_idx", 32'(o_idx_split), 32'(s));
    chk("rd_err", 32'(o_rd_err), 32'(err));
    if (err) begin
      chk("err_no_en", 32'(o_uram_mem_en), 32'd0);
      end_cyc = t;
      tick();
      chk("err_no_en_next", 32'(o_uram_mem_en), 32'd0);
      chk("err_one_pulse", 32'(o_rd_err), 32'd0);
    end else begin
      beats = 0;
      first_valid = -1;
      last_valid = -1;
      for (int k = 0; k < int'(RL); k++) exp_q.push_back(k);
      for (int k = 0; k < int'(RL); k++) begin
        tick();
        if (o_uram_rdaddr !== AW'(k) || o_uram_mem_en !== oh || o_uram_we !== '0) bad++;
      end
      chk("rd_addr_seq", 32'(bad), 32'd0);
      bad = 0;
      do begin
        tick();
        n++;
        if (!o_rd_done && o_uram_mem_en !== oh) bad++;
      end while (!o_rd_done && n < 50);
      chk("rd_done_seen", 32'(o_rd_done), 32'd1);
      chk("rd_drain_en", 32'(bad), 32'd0);
      chk("rd_done_lat", 32'(cyc - t), 32'(RL + UD + 1));
      chk("rd_first_valid", 32'(first_valid - t), 32'(UD + 1));
      chk("rd_beats", 32'(beats), 32'(RL));
      chk("rd_contig", 32'(last_valid - first_valid), 32'(RL - 1));
      chk("rd_done_after_last", 32'(cyc - last_valid), 32'd1);
      chk("rd_q_empty", 32'(exp_q.size()), 32'd0);
      chk("rd_en_drop", 32'(o_uram_mem_en), 32'd0);
      end_cyc = cyc;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic gw, gr, pend_w, pend_r, first;
    int gc, prev_end, n;

    //          wr    rd    ws    rs    nlow inv   wr_1st err   loaded
    vecs[0] = '{1'b1, 1'b0, 2'd2, 2'd0, 20,  1'b0, 1'b1, 1'b0, 4'b0100};
    vecs[1] = '{1'b0, 1'b1, 2'd0, 2'd2, 1,   1'b0, 1'b0, 1'b0, 4'b0100};
    vecs[2] = '{1'b1, 1'b1, 2'd0, 2'd0, 4,   1'b0, 1'b1, 1'b0, 4'b0101};
    vecs[3] = '{1'b1, 1'b1, 2'd0, 2'd2, 3,   1'b0, 1'b1, 1'b0, 4'b0101};
    vecs[4] = '{1'b0, 1'b1, 2'd0, 2'd1, 1,   1'b0, 1'b0, 1'b1, 4'b0101};
    vecs[5] = '{1'b1, 1'b0, 2'd3, 2'd0, 6,   1'b1, 1'b1, 1'b0, 4'b1000};
    vecs[6] = '{1'b1, 1'b1, 2'd1, 2'd3, 2,   1'b0, 1'b0, 1'b0, 4'b1010};
    vecs[7] = '{1'b1, 1'b1, 2'd2, 2'd0, 5,   1'b0, 1'b0, 1'b1, 4'b1110};

    for (int i = 0; i <= int'(UD); i++) hist[i] = '0;
    beats = 0;
    first_valid = -1;
    last_valid = -1;
    rst = 1'b1;
    i_wr_req = 1'b0;
    i_rd_req = 1'b0;
    i_wr_split = '0;
    i_rd_split = '0;
    i_invalidate = 1'b0;
    i_wruram_done = 1'b1;
    repeat (3) tick();
    chk("rst_ctrl", {27'd0, o_wr_gnt, o_wr_done, o_rd_gnt, o_rd_err, o_rd_done}, 32'd0);
    chk("rst_store", {25'd0, o_wruram_start, o_rd_valid, o_uram_mem_en}, 32'd0);
    chk("rst_addr", 32'(o_uram_rdaddr), 32'd0);
    chk("rst_loaded", 32'(o_split_loaded), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      pend_w = v.wr;
      pend_r = v.rd;
      first = 1'b1;
      prev_end = cyc;
      i_wr_req = v.wr;
      i_wr_split = v.ws;
      i_rd_req = v.rd;
      i_rd_split = v.rs;
      while (pend_w || pend_r) begin
        wait_gnt(gw, gr, gc);
        if (!(gw || gr)) break;
        chk("one_gnt", 32'(gw && gr), 32'd0);
        chk("gnt_expected", 32'(gw ? pend_w : pend_r), 32'd1);
        if (first && v.wr && v.rd) chk("arb_first_wr", 32'(gw), 32'(v.wr_first));
        if (!first) chk("b2b_gnt", 32'(gc - prev_end), 32'd1);
        first = 1'b0;
        if (gw) begin
          i_wr_req = 1'b0;
          pend_w = 1'b0;
          do_write(v.ws, v.nlow, v.inv, prev_end);
        end else begin
          i_rd_req = 1'b0;
          pend_r = 1'b0;
          do_read(v.rs, v.rd_err, prev_end);
        end
      end
      i_wr_req = 1'b0;
      i_rd_req = 1'b0;
      tick();
      chk("loaded", 32'(o_split_loaded), 32'(v.loaded));
    end

    // Reset in the middle of a stream of split 3.
    i_rd_req = 1'b1;
    i_rd_split = 2'd3;
    wait_gnt(gw, gr, gc);
    i_rd_req = 1'b0;
    chk("mid_rd_gnt", 32'(gr), 32'd1);
    beats = 0;
    for (int k = 0; k < int'(RL); k++) exp_q.push_back(k);
    n = 0;
    while (o_uram_rdaddr !== AW'(7) && n < 50) begin
      tick();
      n++;
    end
    chk("reach_addr7", 32'(o_uram_rdaddr), 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ctrl", {27'd0, o_wr_gnt, o_wr_done, o_rd_gnt, o_rd_err, o_rd_done}, 32'd0);
    chk("mid_rst_store", {25'd0, o_wruram_start, o_rd_valid, o_uram_mem_en}, 32'd0);
    chk("mid_rst_addr", {28'd0, o_uram_rdaddr}, 32'd0);
    chk("mid_rst_idx", 32'(o_idx_split), 32'd0);
    chk("mid_rst_loaded", 32'(o_split_loaded), 32'd0);
    exp_q.delete();
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (o_rd_done || o_rd_valid || o_uram_mem_en != '0) n++;
    end
    chk("post_rst_quiet", 32'(n), 32'd0);

    // A fresh load after the abort completes normally.
    i_wr_req = 1'b1;
    i_wr_split = 2'd1;
    wait_gnt(gw, gr, gc);
    i_wr_req = 1'b0;
    chk("post_rst_wr_gnt", 32'(gw), 32'd1);
    if (gw) do_write(2'd1, 5, 1'b0, prev_end);
    tick();
    chk("post_rst_loaded", 32'(o_split_loaded), 32'b0010);

    // Invalidate while idle clears everything.
    i_invalidate = 1'b1;
    tick();
    i_invalidate = 1'b0;
    chk("inv_idle", 32'(o_split_loaded), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
